// File: rtl/text_ram_arbiter_if.sv
// Signal bundle shared by the text RAM arbiter, its requesters and the character RAM.
// master = requester/RAM side, slave = arbiter side.
interface text_ram_arbiter_if #(
  parameter int ADDR_W = 12
);
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic [7:0]        disp_data;
  logic              disp_valid;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              wr_ack;
  logic              wr_err;
  logic              clr_start;
  logic              clr_busy;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;

  modport master (
    output disp_req, disp_addr, wr_req, wr_addr, wr_data, clr_start, ram_rdata,
    input  disp_data, disp_valid, wr_ack, wr_err, clr_busy, ram_addr, ram_we, ram_wdata
  );

  modport slave (
    input  disp_req, disp_addr, wr_req, wr_addr, wr_data, clr_start, ram_rdata,
    output disp_data, disp_valid, wr_ack, wr_err, clr_busy, ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/text_ram_arbiter.sv
// Character RAM arbiter: display fetches own every slot they ask for, host writes and the
// optional bulk-clear engine (enabled by defining TEXT_ARB_CLEAR_EN) take the rest.
module text_ram_arbiter #(
  parameter int         ADDR_W    = 12,
  parameter int         DEPTH     = 2400,
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input logic               clk,
  input logic               rst,
  text_ram_arbiter_if.slave bus
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    OWN_IDLE,
    OWN_DISP,
    OWN_WRITE,
    OWN_CLEAR
  } owner_t;

  owner_t owner, owner_nx;

  logic [ADDR_W-1:0] ram_addr_q, ram_addr_nx;
  logic              ram_we_q, ram_we_nx;
  logic [7:0]        ram_wdata_q, ram_wdata_nx;
  logic              wr_ack_q, wr_ack_nx;
  logic              wr_err_q, wr_err_nx;
  logic              rd_pend;
  logic              disp_valid_q;
  logic [7:0]        disp_data_q;
  logic              wr_in_range;
  logic              wr_hold;
  logic              clr_pending;
  logic              clr_busy_q;
  logic [ADDR_W-1:0] clr_addr;

  assign wr_in_range = (bus.wr_addr <= LAST_ADDR);

`ifdef TEXT_ARB_CLEAR_EN
  logic clr_last_q;

  // clr_last_q marks the cycle the final fill write is on the RAM port; busy drops one cycle later
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clr_busy_q <= 1'b0;
      clr_last_q <= 1'b0;
      clr_addr   <= '0;
    end else if (!clr_busy_q) begin
      if (bus.clr_start) begin
        clr_busy_q <= 1'b1;
        clr_last_q <= 1'b0;
        clr_addr   <= '0;
      end
    end else if (clr_last_q) begin
      clr_busy_q <= 1'b0;
      clr_last_q <= 1'b0;
      clr_addr   <= '0;
    end else if (owner_nx == OWN_CLEAR) begin
      if (clr_addr == LAST_ADDR) clr_last_q <= 1'b1;
      else                       clr_addr   <= clr_addr + ADDR_W'(1);
    end
  end

  assign clr_pending = clr_busy_q && !clr_last_q;
  assign wr_hold     = clr_busy_q;
`else
  logic unused_clr_start;
  assign unused_clr_start = bus.clr_start;
  assign clr_busy_q       = 1'b0;
  assign clr_pending      = 1'b0;
  assign wr_hold          = 1'b0;
  assign clr_addr         = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) owner <= OWN_IDLE;
    else      owner <= owner_nx;
  end

  // Fixed priority: display, then host write (unless a clear holds it off), then clear
  always_comb begin
    owner_nx = OWN_IDLE;
    if (bus.disp_req)               owner_nx = OWN_DISP;
    else if (bus.wr_req && !wr_hold) owner_nx = OWN_WRITE;
    else if (clr_pending)            owner_nx = OWN_CLEAR;
  end

  always_comb begin
    ram_addr_nx  = ram_addr_q;
    ram_we_nx    = 1'b0;
    ram_wdata_nx = ram_wdata_q;
    wr_ack_nx    = 1'b0;
    wr_err_nx    = 1'b0;
    case (owner_nx)
      OWN_DISP: ram_addr_nx = bus.disp_addr;
      OWN_WRITE: begin
        wr_ack_nx = 1'b1;
        if (wr_in_range) begin
          ram_addr_nx  = bus.wr_addr;
          ram_we_nx    = 1'b1;
          ram_wdata_nx = bus.wr_data;
        end else begin
          wr_err_nx = 1'b1;
        end
      end
      OWN_CLEAR: begin
        ram_addr_nx  = clr_addr;
        ram_we_nx    = 1'b1;
        ram_wdata_nx = FILL_CHAR;
      end
      default: ;
    endcase
  end

  // RAM port and host response registers, plus the 3-cycle display return pipe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_addr_q   <= '0;
      ram_we_q     <= 1'b0;
      ram_wdata_q  <= '0;
      wr_ack_q     <= 1'b0;
      wr_err_q     <= 1'b0;
      rd_pend      <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
    end else begin
      ram_addr_q   <= ram_addr_nx;
      ram_we_q     <= ram_we_nx;
      ram_wdata_q  <= ram_wdata_nx;
      wr_ack_q     <= wr_ack_nx;
      wr_err_q     <= wr_err_nx;
      rd_pend      <= (owner == OWN_DISP);
      disp_valid_q <= rd_pend;
      if (rd_pend) disp_data_q <= bus.ram_rdata;
    end
  end

  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_we     = ram_we_q;
  assign bus.ram_wdata  = ram_wdata_q;
  assign bus.wr_ack     = wr_ack_q;
  assign bus.wr_err     = wr_err_q;
  assign bus.disp_valid = disp_valid_q;
  assign bus.disp_data  = disp_data_q;
  assign bus.clr_busy   = clr_busy_q;
endmodule
